// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps a,b,c through 000..111 and captures f1/f2 truth tables
module truth_table_sweeper #(
   parameter int DWELL = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       f1,
   input  logic       f2,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic [7:0] tt_f1,
   output logic [7:0] tt_f2
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

   state_t     state, state_nxt;
   logic [2:0] idx, idx_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       busy_nxt, done_nxt;
   logic [7:0] tt_f1_nxt, tt_f2_nxt;

   // Stimulus is the registered vector index itself, so a/b/c change on the sampling edge.
   assign a = idx[2];
   assign b = idx[1];
   assign c = idx[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= 3'd0;
         cnt   <= 8'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
         tt_f1 <= 8'h00;
         tt_f2 <= 8'h00;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         tt_f1 <= tt_f1_nxt;
         tt_f2 <= tt_f2_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      tt_f1_nxt = tt_f1;
      tt_f2_nxt = tt_f2;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = DRIVE;
               idx_nxt   = 3'd0;
               cnt_nxt   = 8'd0;
               busy_nxt  = 1'b1;
               tt_f1_nxt = 8'h00;
               tt_f2_nxt = 8'h00;
            end
         end
         DRIVE: begin
            if (abort) begin
               state_nxt = IDLE;
               idx_nxt   = 3'd0;
               cnt_nxt   = 8'd0;
               busy_nxt  = 1'b0;
            end else if (cnt != CNT_LAST) begin
               cnt_nxt = cnt + 8'd1;
            end else begin
               // End of dwell: the block has had the whole dwell to settle on this vector.
               tt_f1_nxt[idx] = f1;
               tt_f2_nxt[idx] = f2;
               cnt_nxt        = 8'd0;
               if (idx != 3'd7) begin
                  idx_nxt = idx + 3'd1;
               end else begin
                  state_nxt = DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

   localparam int DW  = 3;
   localparam int SPAN = 8 * DW;

   logic       clk = 1'b0;
   logic       rst, start, abort, f1, f2;
   logic       a, b, c, busy, done;
   logic [7:0] tt_f1, tt_f2;

   int         test_cnt = 0;
   int         err_cnt  = 0;
   int         mode;
   logic [7:0] tbl1, tbl2;

   truth_table_sweeper #(.DWELL(DW)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .abort (abort),
      .f1    (f1),
      .f2    (f2),
      .a     (a),
      .b     (b),
      .c     (c),
      .busy  (busy),
      .done  (done),
      .tt_f1 (tt_f1),
      .tt_f2 (tt_f2)
   );

   always #5 clk = ~clk;

   // Stand-in combinational block: random tables, parity/majority, or and3/not-c.
   always_comb begin
      logic [2:0] v;
      v = {a, b, c};
      f1 = 1'b0;
      f2 = 1'b0;
      case (mode)
         0: begin
            f1 = tbl1[v];
            f2 = tbl2[v];
         end
         1: begin
            f1 = a ^ b ^ c;
            f2 = (a & b) | (a & c) | (b & c);
         end
         default: begin
            f1 = a & b & c;
            f2 = ~c;
         end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      test_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_tt1();
      case (mode)
         0:       return tbl1;
         1:       return 8'h96;
         default: return 8'h80;
      endcase
   endfunction

   function automatic logic [7:0] exp_tt2();
      case (mode)
         0:       return tbl2;
         1:       return 8'hE8;
         default: return 8'h55;
      endcase
   endfunction

   function automatic int exp_vec(input int t);
      return (t / DW > 7) ? 7 : t / DW;
   endfunction

   task automatic begin_sweep();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("accept_busy", busy, 1);
      check("accept_abc", {a, b, c}, 0);
   endtask

   task automatic run_sweep(input int m, input bit repulse);
      int dones;
      mode  = m;
      tbl1  = 8'($urandom);
      tbl2  = 8'($urandom);
      dones = 0;
      begin_sweep();
      for (int t = 1; t <= SPAN; t++) begin
         @(negedge clk);
         start = repulse && (t == 3 * DW + 1);
         check("sweep_abc", {a, b, c}, exp_vec(t));
         check("sweep_busy", busy, (t < SPAN));
         check("sweep_done", done, (t == SPAN));
         dones += done;
      end
      check("tt_f1", tt_f1, exp_tt1());
      check("tt_f2", tt_f2, exp_tt2());
      @(negedge clk);
      start = 1'b0;
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("done_count", dones, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic abort_sweep(input int v);
      int dones;
      mode  = 0;
      tbl1  = 8'($urandom);
      tbl2  = 8'($urandom);
      dones = 0;
      begin_sweep();
      for (int t = 1; t <= v * DW + 1; t++) @(negedge clk);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_abc", {a, b, c}, 0);
      check("abort_done", done, 0);
      check("abort_tt_f1", tt_f1, tbl1 & 8'((1 << v) - 1));
      check("abort_tt_f2", tt_f2, tbl2 & 8'((1 << v) - 1));
      repeat (SPAN + 4) begin
         @(negedge clk);
         dones += done;
      end
      check("abort_no_done", dones, 0);
   endtask

   initial begin
      int done_t[3];
      int nd;
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      mode  = 1;
      tbl1  = 8'h00;
      tbl2  = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_abc", {a, b, c}, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_tt", {tt_f1, tt_f2}, 0);

      run_sweep(1, 1'b0);
      run_sweep(2, 1'b0);
      run_sweep(0, 1'b1);
      for (int i = 0; i < 4; i++) run_sweep(0, 1'b0);

      // Reset in the middle of a sweep that already captured nonzero bits.
      mode = 2;
      begin_sweep();
      repeat (7 * DW + 1) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("midrst_abc", {a, b, c}, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_tt", {tt_f1, tt_f2}, 0);
      @(negedge clk);
      check("midrst_idle", busy, 0);

      abort_sweep(3);
      for (int i = 0; i < 3; i++) abort_sweep($urandom_range(1, 7));

      // start and abort together in IDLE: start wins, then abort at vector 0.
      @(negedge clk) begin
         start = 1'b1;
         abort = 1'b1;
      end
      @(negedge clk) begin
         start = 1'b0;
         abort = 1'b0;
      end
      check("start_wins", busy, 1);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      check("abort_v0_busy", busy, 0);
      check("abort_v0_tt", {tt_f1, tt_f2}, 0);

      // Start held high: sweeps back to back.
      mode  = 1;
      nd    = 0;
      @(negedge clk) start = 1'b1;
      for (int cyc = 0; cyc < 10 * SPAN && nd < 3; cyc++) begin
         @(negedge clk);
         if (done) begin
            done_t[nd] = cyc;
            nd++;
         end
      end
      start = 1'b0;
      check("held_pulses", nd, 3);
      if (nd == 3) begin
         check("held_gap1", done_t[1] - done_t[0], SPAN + 2);
         check("held_gap2", done_t[2] - done_t[1], SPAN + 2);
         check("held_tt", {tt_f1, tt_f2}, 16'h96E8);
      end
      repeat (SPAN + 4) @(negedge clk);
      check("held_released", busy, 0);

      $display("[TB] %0d tests run, %0d failed", test_cnt, err_cnt);
      $finish;
   end

endmodule
